// File: rtl/serial_subtractor_pkg.sv
// Shared arithmetic package for the bit-serial datapaths.
// Holds the FSM state encoding and the default operand width.
package serial_arith_pkg;

  localparam int SERSUB_DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Host-side bundle for serial_subtractor: start/busy/done, operands, result and serial tap.
// Carries ovf only when SERSUB_OVF_EN is defined.
interface serial_subtractor_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             diff_bit;
  logic             diff_bit_vld;
`ifdef SERSUB_OVF_EN
  logic             ovf;

  modport master (output start, a, b,
                  input  busy, done, diff, bout, diff_bit, diff_bit_vld, ovf);
  modport slave  (input  start, a, b,
                  output busy, done, diff, bout, diff_bit, diff_bit_vld, ovf);
`else
  modport master (output start, a, b,
                  input  busy, done, diff, bout, diff_bit, diff_bit_vld);
  modport slave  (input  start, a, b,
                  output busy, done, diff, bout, diff_bit, diff_bit_vld);
`endif
endinterface

// File: rtl/serial_subtractor_fs.sv
// Single-bit full subtractor cell: d = x - y - bin, with borrow out.
// Combinational twin of the full-adder cell used elsewhere in the datapath.
module full_subtractor (
  input  logic x_i,
  input  logic y_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  assign d_o    = x_i ^ y_i ^ bin_i;
  assign bout_o = (~x_i & y_i) | (~(x_i ^ y_i) & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one full_subtractor plus a borrow flop.
// Optional signed-overflow output enabled by defining SERSUB_OVF_EN.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = SERSUB_DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  sub_state_e       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, diff_q, diff_d;
  logic [WIDTH-2:0] acc_q, acc_d;
  logic [WIDTH-1:0] acc_shift;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             br_q, br_d, bout_q, bout_d, done_q, done_d;
  logic             dbit_q, dbit_d, dvld_q, dvld_d;
  logic             fs_d, fs_bo, last;
`ifdef SERSUB_OVF_EN
  logic             amsb_q, amsb_d, bmsb_q, bmsb_d, ovf_q, ovf_d;
`endif

  full_subtractor u_fs (
    .x_i    (sa_q[0]),
    .y_i    (sb_q[0]),
    .bin_i  (br_q),
    .d_o    (fs_d),
    .bout_o (fs_bo)
  );

  assign last      = (cnt_q == CNT_W'(WIDTH-1));
  // Current bit enters at the MSB; the full vector is the final result on the last edge.
  assign acc_shift = {fs_d, acc_q};

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    dbit_d  = dbit_q;
    done_d  = 1'b0;
    dvld_d  = 1'b0;
`ifdef SERSUB_OVF_EN
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sa_d    = bus.a;
          sb_d    = bus.b;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
`ifdef SERSUB_OVF_EN
          amsb_d  = bus.a[WIDTH-1];
          bmsb_d  = bus.b[WIDTH-1];
`endif
        end
      end
      RUN: begin
        dbit_d = fs_d;
        dvld_d = 1'b1;
        br_d   = fs_bo;
        sa_d   = sa_q >> 1;
        sb_d   = sb_q >> 1;
        acc_d  = acc_shift[WIDTH-1:1];
        cnt_d  = cnt_q + CNT_W'(1);
        if (last) begin
          diff_d  = acc_shift;
          bout_d  = fs_bo;
          done_d  = 1'b1;
          state_d = DONE;
`ifdef SERSUB_OVF_EN
          ovf_d   = (amsb_q != bmsb_q) && (fs_d != amsb_q);
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      dbit_q  <= 1'b0;
      done_q  <= 1'b0;
      dvld_q  <= 1'b0;
`ifdef SERSUB_OVF_EN
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      dbit_q  <= dbit_d;
      done_q  <= done_d;
      dvld_q  <= dvld_d;
`ifdef SERSUB_OVF_EN
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = done_q;
  assign bus.diff         = diff_q;
  assign bus.bout         = bout_q;
  assign bus.diff_bit     = dbit_q;
  assign bus.diff_bit_vld = dvld_q;
`ifdef SERSUB_OVF_EN
  assign bus.ovf          = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8): results, serial stream, ignored start,
// mid-run reset, back-to-back throughput, and signed overflow when SERSUB_OVF_EN is set.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errs = 0;
  int   checks = 0;
  logic [7:0] prev_diff = 8'h00;
  logic       prev_bout = 1'b0;
  logic [7:0] bb_a [4];
  logic [7:0] bb_b [4];
  logic [7:0] bb_d [3];
  logic       bb_bo [3];

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) bus ();

  serial_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered at posedge+1 with the DUT idle; leaves at posedge+1 with the DUT idle again.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] ed,
                        input logic eb, input logic eo, input bit poke);
    bus.start = 1'b1; bus.a = av; bus.b = bv;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = 8'hA5; bus.b = 8'h5A;
    chk("busy_after_start", bus.busy, 1'b1);
    chk("done_after_start", bus.done, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (poke && i == 2) begin
        bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h01;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("vld_run", bus.diff_bit_vld, 1'b1);
      chk("diff_bit", bus.diff_bit, ed[i]);
      if (i < 7) begin
        chk("done_early", bus.done, 1'b0);
        chk("diff_hold_run", bus.diff, prev_diff);
        chk("bout_hold_run", bus.bout, prev_bout);
      end else begin
        chk("done_pulse", bus.done, 1'b1);
        chk("diff_result", bus.diff, ed);
        chk("bout_result", bus.bout, eb);
`ifdef SERSUB_OVF_EN
        chk("ovf_result", bus.ovf, eo);
`else
        if (eo) chk("ovf_unused", bus.busy, 1'b1);
`endif
      end
    end
    @(posedge clk); #1;
    chk("done_cleared", bus.done, 1'b0);
    chk("vld_cleared", bus.diff_bit_vld, 1'b0);
    chk("busy_cleared", bus.busy, 1'b0);
    chk("diff_hold", bus.diff, ed);
    prev_diff = ed;
    prev_bout = eb;
  endtask

  initial begin
    bus.start = 1'b0; bus.a = 8'h00; bus.b = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_diff", bus.diff, 8'h00);
    chk("rst_bout", bus.bout, 1'b0);
    chk("rst_vld", bus.diff_bit_vld, 1'b0);
    chk("rst_bit", bus.diff_bit, 1'b0);
`ifdef SERSUB_OVF_EN
    chk("rst_ovf", bus.ovf, 1'b0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0);
    run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0);
    run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0);
    run_op(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
    // second start three cycles into RUN must be ignored
    run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b1);
    repeat (2) begin
      @(posedge clk); #1;
      chk("poke_not_queued", bus.busy, 1'b0);
    end

    // reset with cnt=4
    bus.start = 1'b1; bus.a = 8'h05; bus.b = 8'h03;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_busy", bus.busy, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_diff", bus.diff, 8'h00);
    chk("abort_bout", bus.bout, 1'b0);
    chk("abort_vld", bus.diff_bit_vld, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    repeat (6) begin
      @(posedge clk); #1;
      chk("abort_no_done", bus.done, 1'b0);
    end
    prev_diff = 8'h00;
    prev_bout = 1'b0;
    run_op(8'h21, 8'h42, 8'hDF, 1'b1, 1'b0, 1'b0);

    // start held high: accepted every 10 cycles
    bb_a[0] = 8'h0A; bb_b[0] = 8'h04; bb_d[0] = 8'h06; bb_bo[0] = 1'b0;
    bb_a[1] = 8'h10; bb_b[1] = 8'h20; bb_d[1] = 8'hF0; bb_bo[1] = 1'b1;
    bb_a[2] = 8'h81; bb_b[2] = 8'h01; bb_d[2] = 8'h80; bb_bo[2] = 1'b0;
    bb_a[3] = 8'h00; bb_b[3] = 8'h00;
    bus.start = 1'b1; bus.a = bb_a[0]; bus.b = bb_b[0];
    @(posedge clk); #1;
    chk("bb_busy0", bus.busy, 1'b1);
    bus.a = bb_a[1]; bus.b = bb_b[1];
    for (int k = 1; k < 30; k++) begin
      @(posedge clk); #1;
      chk("bb_done", bus.done, (k % 10) == 8);
      chk("bb_busy", bus.busy, (k % 10) != 9);
      if (k >= 8) begin
        chk("bb_diff", bus.diff, bb_d[(k - 8) / 10]);
        chk("bb_bout", bus.bout, bb_bo[(k - 8) / 10]);
      end
      if (k % 10 == 0) begin
        bus.a = bb_a[k / 10 + 1]; bus.b = bb_b[k / 10 + 1];
      end
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("bb_idle", bus.busy, 1'b0);
    prev_diff = 8'h80;
    prev_bout = 1'b0;

`ifdef SERSUB_OVF_EN
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
    run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0);
    run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor that computes diff = a - b one bit per clock, LSB first.
- Built around a single full-subtractor cell plus a registered borrow.
- It is the inverse-arithmetic counterpart of the team's full-adder datapath. It serves as a compact, low-area subtract unit for control paths where latency is acceptable.
- Host interface is start/busy/done, with a serial bit-stream tap for debug or downstream serial consumers.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepted start.
- b  input  WIDTH  subtrahend; captured on the accepted start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; diff/bout are valid from this cycle.
- diff  output  WIDTH  result register; holds until the next accepted start.
- bout  output  1  final borrow (1 when a < b unsigned); holds with diff.
- diff_bit  output  1  serial difference bit produced this cycle.
- diff_bit_vld  output  1  high for each of the WIDTH cycles in RUN.

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE.
  - busy, done, diff_bit, diff_bit_vld, bout and ovf (if present) go to 0.
  - diff and all internal shift registers go to 0, and the counter goes to 0.
- Reset mid-RUN aborts the operation with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches a into sa and b into sb.
  - Borrow register br is cleared to 0 and counter cnt is cleared to 0.
  - Next state is RUN.
  - start=0 stays in IDLE.
- RUN, each cycle:
  - Bits: x=sa[0], y=sb[0].
  - d = x ^ y ^ br.
  - bo = (~x & y) | (~(x ^ y) & br).
  - On the edge: diff_bit<=d, diff_bit_vld<=1, br<=bo.
  - sa and sb shift right by 1.
  - d shifts into an accumulator at MSB, shifting right; after WIDTH shifts bit i sits at position i.
  - cnt increments.
  - When cnt==WIDTH-1 on this edge:
    - diff loads the final accumulator value including the current d.
    - bout<=bo, done<=1.
    - Next state is DONE.
- DONE lasts exactly one cycle:
  - done=1 and diff_bit_vld=0.
  - Next state is IDLE, with done<=0.
  - start during DONE is ignored.
- Latency: start sampled at edge E.
  - diff_bit_vld is high for the cycles after edges E+1..E+WIDTH.
  - done is high for the cycle after edge E+WIDTH.
  - diff, bout and done are visible simultaneously.
- Throughput: one operation per WIDTH+2 cycles maximum.
- start while busy=1 is ignored; a and b are not re-sampled.
- a and b may change freely after the accepted start.
- Arithmetic is modulo 2^WIDTH. bout is unsigned borrow out of the MSB.
- diff is not updated during RUN. It changes only on the final RUN edge or on reset.
- diff_bit is meaningful only while diff_bit_vld=1; it holds its last value otherwise.

Optional Feature:
- Macro: SERSUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit).
  - The MSBs of a and b are latched at start.
  - On the final RUN edge, ovf <= (a_msb != b_msb) && (d != a_msb), i.e. two's-complement signed overflow.
  - ovf is valid with done and holds with diff; reset value is 0.
- Undefined: no ovf port and no extra registers. All other behaviour is identical.

Decomposition:
- Shared package serial_arith_pkg holds:
  - FSM state encoding typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Default-width constant.
- One sub-module, full_subtractor: combinational (x, y, bin) -> (d, bout). It mirrors the team's full adder cell and is instantiated once.
- Counter width is $clog2(WIDTH).

Test Plan:
- WIDTH=8, a=0x05, b=0x03, start one cycle → done after 9 cycles; diff=0x02, bout=0; diff_bit stream 0,1,0,0,0,0,0,0.
- a=0x03, b=0x05 → diff=0xFE, bout=1; a=0x00, b=0x01 → diff=0xFF, bout=1; a=0xFF, b=0xFF → diff=0x00, bout=0.
- start asserted again 3 cycles into RUN with a=0x10, b=0x01 → ignored; result is still the first operation's value, with exactly one done pulse.
- rst_n low for one edge mid-RUN (cnt=4) → next cycle busy=0, diff=0x00, bout=0, diff_bit_vld=0, no done pulse. A new start afterwards completes normally.
- Back-to-back: start held high continuously → operations accepted every 10 cycles; diff holds each result until the next done.
- With SERSUB_OVF_EN:
  - a=0x80, b=0x01 → diff=0x7F, ovf=1.
  - a=0x7F, b=0xFF → diff=0x80, ovf=1.
  - a=0x05, b=0x03 → ovf=0.
